// File: rtl/frame_pattern_decoder.sv
// Maple bus frame pattern decoder: synchronises SDCKA/SDCKB, detects start/end
// patterns, and flags frame boundaries plus malformed or timed-out patterns.
module frame_pattern_decoder #(
    parameter int unsigned START_PULSES = 4,
    parameter int unsigned END_PULSES   = 2,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned CW           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sdcka_in,
    input  logic sdckb_in,
    output logic sdcka_s,
    output logic sdckb_s,
    output logic start_detected,
    output logic end_detected,
    output logic in_frame,
    output logic pattern_error
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        S_COUNT = 4'b0010,
        FRAME   = 4'b0100,
        E_COUNT = 4'b1000
    } state_e;

    localparam logic [3:0]    START_CNT = 4'(START_PULSES);
    localparam logic [3:0]    END_CNT   = 4'(END_PULSES);
    localparam logic [CW-1:0] TMO_CNT   = CW'(TIMEOUT);

    // Synchroniser chain plus one-cycle delayed copy for edge detection.
    logic a_meta_q, a_meta_d, a_s_q, a_s_d, a_d_q, a_d_d;
    logic b_meta_q, b_meta_d, b_s_q, b_s_d, b_d_q, b_d_d;

    state_e        state_q, state_d;
    logic [3:0]    pcnt_q, pcnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          start_q, start_d;
    logic          end_q, end_d;
    logic          err_q, err_d;
    logic          in_frame_q, in_frame_d;

    logic a_fall, a_rise, b_fall, b_rise, a_edge, b_edge, abort;

    assign a_fall = a_d_q & ~a_s_q;
    assign a_rise = a_s_q & ~a_d_q;
    assign b_fall = b_d_q & ~b_s_q;
    assign b_rise = b_s_q & ~b_d_q;
    assign a_edge = a_fall | a_rise;
    assign b_edge = b_fall | b_rise;

    always_comb begin
        a_meta_d = sdcka_in;
        a_s_d    = a_meta_q;
        a_d_d    = a_s_q;
        b_meta_d = sdckb_in;
        b_s_d    = b_meta_q;
        b_d_d    = b_s_q;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        tcnt_d     = tcnt_q;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        in_frame_d = in_frame_q;
        abort      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_fall && !b_edge && b_s_q) begin
                    state_d = S_COUNT;
                    pcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            S_COUNT: begin
                if (a_edge && b_edge) begin
                    abort = 1'b1;
                end else if (a_rise) begin
                    if (pcnt_q == START_CNT && b_s_q) begin
                        start_d    = 1'b1;
                        in_frame_d = 1'b1;
                        state_d    = FRAME;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (b_fall && !a_s_q) begin
                    pcnt_d = (pcnt_q == 4'hF) ? pcnt_q : pcnt_q + 4'd1;
                    tcnt_d = '0;
                end else if (tcnt_q == TMO_CNT) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
                end
            end
            FRAME: begin
                if (b_fall && !a_edge && a_s_q) begin
                    state_d = E_COUNT;
                    pcnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            E_COUNT: begin
                if (a_edge && b_edge) begin
                    abort = 1'b1;
                end else if (b_rise) begin
                    // Fewer than two A pulses inside B-low is just a data bit.
                    if (pcnt_q == END_CNT && a_s_q) begin
                        end_d      = 1'b1;
                        in_frame_d = 1'b0;
                        state_d    = IDLE;
                    end else if (pcnt_q < 4'd2) begin
                        state_d = FRAME;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (a_fall && !b_s_q) begin
                    pcnt_d = (pcnt_q == 4'hF) ? pcnt_q : pcnt_q + 4'd1;
                    tcnt_d = '0;
                end else if (tcnt_q == TMO_CNT) begin
                    abort = 1'b1;
                end else begin
                    tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            in_frame_d = 1'b0;
            pcnt_d     = '0;
            tcnt_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_meta_q   <= 1'b1;
            a_s_q      <= 1'b1;
            a_d_q      <= 1'b1;
            b_meta_q   <= 1'b1;
            b_s_q      <= 1'b1;
            b_d_q      <= 1'b1;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            a_meta_q   <= a_meta_d;
            a_s_q      <= a_s_d;
            a_d_q      <= a_d_d;
            b_meta_q   <= b_meta_d;
            b_s_q      <= b_s_d;
            b_d_q      <= b_d_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            tcnt_q     <= tcnt_d;
            start_q    <= start_d;
            end_q      <= end_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign sdcka_s        = a_s_q;
    assign sdckb_s        = b_s_q;
    assign start_detected = start_q;
    assign end_detected   = end_q;
    assign pattern_error  = err_q;
    assign in_frame       = in_frame_q;

endmodule

// File: tb/tb_frame_pattern_decoder.sv
// Scoreboard bench for frame_pattern_decoder: directed scenarios plus random
// line activity, checked against a transition-level pattern model.
module tb_frame_pattern_decoder;

    localparam int TIMEOUT = 1000;
    localparam int START_N = 4;
    localparam int END_N   = 2;
    localparam int LAT     = 3;

    logic clk = 1'b0;
    logic reset;
    logic sdcka_in, sdckb_in;
    logic sdcka_s, sdckb_s, start_detected, end_detected, in_frame, pattern_error;

    frame_pattern_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .sdcka_in       (sdcka_in),
        .sdckb_in       (sdckb_in),
        .sdcka_s        (sdcka_s),
        .sdckb_s        (sdckb_s),
        .start_detected (start_detected),
        .end_detected   (end_detected),
        .in_frame       (in_frame),
        .pattern_error  (pattern_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pulse: {start, end, error} vector, allowed cycle window, in_frame after it.
    typedef struct {
        logic [2:0] vec;
        int         lo;
        int         hi;
        logic       inf;
    } ev_t;

    localparam logic [2:0] EV_START = 3'b100;
    localparam logic [2:0] EV_END   = 3'b010;
    localparam logic [2:0] EV_ERR   = 3'b001;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_window(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Pattern model: works on whole-line transitions, not on clock-level state.
    typedef enum {M_IDLE, M_START, M_FRAME, M_END} mode_e;
    mode_e m_mode = M_IDLE;
    int    m_cnt  = 0;
    int    m_last = 0;
    logic  m_inf  = 1'b0;
    logic  m_a    = 1'b1;
    logic  m_b    = 1'b1;

    task automatic expect_ev(input logic [2:0] vec, input int lo, input int hi, input logic inf);
        ev_t e;
        e.vec = vec; e.lo = lo; e.hi = hi; e.inf = inf;
        exp_q.push_back(e);
    endtask

    task automatic model_error(input int r);
        m_mode = M_IDLE;
        m_inf  = 1'b0;
        expect_ev(EV_ERR, r + LAT, r + LAT, 1'b0);
    endtask

    task automatic model_step(input logic na, input logic nb, input int r);
        bit af, ar, bf, br, both;
        af   = m_a && !na;
        ar   = !m_a && na;
        bf   = m_b && !nb;
        br   = !m_b && nb;
        both = (af || ar) && (bf || br);
        case (m_mode)
            M_IDLE: if (!both && af && nb) begin
                m_mode = M_START; m_cnt = 0; m_last = r;
            end
            M_START: begin
                if (both) model_error(r);
                else if (ar) begin
                    if (m_cnt == START_N && nb) begin
                        m_mode = M_FRAME; m_inf = 1'b1;
                        expect_ev(EV_START, r + LAT, r + LAT, 1'b1);
                    end else model_error(r);
                end else if (bf && !na) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15; m_last = r;
                end
            end
            M_FRAME: if (!both && bf && na) begin
                m_mode = M_END; m_cnt = 0; m_last = r;
            end
            M_END: begin
                if (both) model_error(r);
                else if (br) begin
                    if (m_cnt == END_N && na) begin
                        m_mode = M_IDLE; m_inf = 1'b0;
                        expect_ev(EV_END, r + LAT, r + LAT, 1'b0);
                    end else if (m_cnt < 2) m_mode = M_FRAME;
                    else model_error(r);
                end else if (af && !nb) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15; m_last = r;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_a = na;
        m_b = nb;
    endtask

    // Change the lines, hold them, then confirm levels seen by the DUT.
    task automatic drive(input logic na, input logic nb, input int hold);
        @(negedge clk);
        model_step(na, nb, cyc);
        if ((m_mode == M_START || m_mode == M_END) && (cyc + hold > m_last + TIMEOUT + 6)) begin
            m_mode = M_IDLE;
            m_inf  = 1'b0;
            expect_ev(EV_ERR, m_last + TIMEOUT + 2, m_last + TIMEOUT + 6, 1'b0);
        end
        sdcka_in = na;
        sdckb_in = nb;
        repeat (hold) @(negedge clk);
        check("in_frame_level", in_frame, m_inf);
        check("sdcka_s_level", sdcka_s, na);
        check("sdckb_s_level", sdckb_s, nb);
    endtask

    task automatic start_seq(input int n, input int w);
        drive(1'b0, 1'b1, w);
        repeat (n) begin
            drive(1'b0, 1'b0, w);
            drive(1'b0, 1'b1, w);
        end
        drive(1'b1, 1'b1, w);
    endtask

    task automatic end_seq(input int n, input int w);
        drive(1'b1, 1'b0, w);
        repeat (n) begin
            drive(1'b0, 1'b0, w);
            drive(1'b1, 1'b0, w);
        end
        drive(1'b1, 1'b1, w);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start"}, start_detected, 0);
        check({tag, "_end"}, end_detected, 0);
        check({tag, "_err"}, pattern_error, 0);
        check({tag, "_in_frame"}, in_frame, 0);
        check({tag, "_sdcka_s"}, sdcka_s, 1);
        check({tag, "_sdckb_s"}, sdckb_s, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        sdcka_in = 1'b1;
        sdckb_in = 1'b1;
        m_mode = M_IDLE; m_inf = 1'b0; m_a = 1'b1; m_b = 1'b1; m_cnt = 0;
        check("no_pending_at_reset", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a pulse is presented.
    logic [2:0] mon_vec;
    logic [2:0] prev_vec = 3'b000;
    ev_t        mon_ev;

    always @(negedge clk) begin
        if (!reset) begin
            prev_vec = 3'b000;
        end else begin
            mon_vec = {start_detected, end_detected, pattern_error};
            while (exp_q.size() > 0 && exp_q[0].hi < cyc) begin
                checks++;
                $display("FAIL missed_event: expected pulse %b by cycle %0d, none by %0d",
                         exp_q[0].vec, exp_q[0].hi, cyc);
                exp_q.delete(0);
            end
            if (mon_vec != 3'b000) begin
                check("pulse_onehot", $countones(mon_vec), 1);
                check("pulse_not_repeated", int'(prev_vec), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(mon_vec), 0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("event_kind", int'(mon_vec), int'(mon_ev.vec));
                    check_window("event_cycle", cyc, mon_ev.lo, mon_ev.hi);
                    check("in_frame_after_event", in_frame, mon_ev.inf);
                end
            end
            prev_vec = mon_vec;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        sdcka_in = 1'b1;
        sdckb_in = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("por");
        reset = 1'b1;

        drive(1'b1, 1'b1, 50);                     // idle bus
        start_seq(START_N, 8);                     // valid start
        end_seq(END_N, 8);                         // valid end
        start_seq(3, 8);                           // too few pulses
        drive(1'b0, 1'b1, 8);                      // timeout mid-start
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, TIMEOUT + 10);
        drive(1'b1, 1'b1, 8);
        start_seq(START_N, 8);                     // start still works after timeout
        end_seq(1, 8);                             // data bit, stays in frame
        end_seq(END_N, 8);
        drive(1'b0, 1'b1, 8);                      // simultaneous edges in S_COUNT
        drive(1'b1, 1'b0, 8);
        drive(1'b1, 1'b1, 8);
        drive(1'b0, 1'b1, 8);                      // reset after two pulses
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 8);
        do_reset();
        start_seq(START_N, 8);
        end_seq(END_N, 8);

        for (int i = 0; i < 150; i++) begin
            int w;
            w = $urandom_range(4, 12);
            case ($urandom_range(0, 6))
                0: start_seq($urandom_range(2, 6), w);
                1: end_seq($urandom_range(0, 3), w);
                2: start_seq(START_N, w);
                3: end_seq(END_N, w);
                4: drive(~m_a, m_b, w);
                5: drive(m_a, ~m_b, w);
                default: drive(~m_a, ~m_b, w);
            endcase
        end

        drive(1'b1, 1'b1, 20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
